// File: rtl/slink_tx_router_pkg.sv
// rtl/slink_tx_router_pkg.sv - shared state/mode encodings and packet-length helpers for the S-Link TX router
package slink_tx_router_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  typedef enum logic {
    ARB_FIXED = 1'b0,
    ARB_RR    = 1'b1
  } arb_mode_e;

  // Wide enough for 16'hFFFF bytes at one byte per beat.
  localparam int unsigned BEAT_CNT_W = 17;

  // Data IDs at or below the threshold carry no payload beyond the header beat.
  function automatic logic is_short_pkt(input logic [7:0] data_id,
                                        input logic [7:0] short_max_id);
    return (data_id <= short_max_id);
  endfunction

  // Rounds the byte count up to whole beats; 17-bit sum keeps 16'hFFFF from wrapping.
  function automatic logic [BEAT_CNT_W-1:0] beat_count(input logic [15:0]   word_count,
                                                       input int unsigned   bpb_log2);
    logic [BEAT_CNT_W-1:0] round_up;
    logic [BEAT_CNT_W-1:0] beats;
    round_up = (17'd1 << bpb_log2) - 17'd1;
    beats    = ({1'b0, word_count} + round_up) >> bpb_log2;
    return (beats == '0) ? 17'd1 : beats;
  endfunction

  // Beats the grant must stay locked for.
  function automatic logic [BEAT_CNT_W-1:0] pkt_beats(input logic [7:0]  data_id,
                                                      input logic [15:0] word_count,
                                                      input logic [7:0]  short_max_id,
                                                      input int unsigned bpb_log2);
    if (is_short_pkt(data_id, short_max_id)) begin
      return 17'd1;
    end
    return beat_count(word_count, bpb_log2);
  endfunction

endpackage

// File: rtl/slink_demet_reset.sv
// rtl/slink_demet_reset.sv - two-flop synchronizer with asynchronous active-high reset
module slink_demet_reset (
  input  logic clk,
  input  logic reset,
  input  logic sig_i,
  output logic sig_o
);

  logic ff1_q;
  logic ff2_q;

  // Two-stage resynchronization of an asynchronous level.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ff1_q <= 1'b0;
      ff2_q <= 1'b0;
    end else begin
      ff1_q <= sig_i;
      ff2_q <= ff1_q;
    end
  end

  assign sig_o = ff2_q;

endmodule

// File: rtl/slink_rr_arbiter.sv
// rtl/slink_rr_arbiter.sv - combinational fixed-priority / round-robin request picker
module slink_rr_arbiter
  import slink_tx_router_pkg::*;
#(
  parameter  int unsigned NUM_REQ = 8,
  localparam int unsigned IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   rr_ptr_i,
  input  logic               mode_i,
  output logic [IDX_W-1:0]   winner_o,
  output logic               valid_o
);

  logic [IDX_W:0]   cand_w;
  logic [IDX_W-1:0] cand;

  // Scan candidates starting at 0 (fixed) or at rr_ptr (round-robin); first hit wins.
  always_comb begin
    winner_o = '0;
    valid_o  = 1'b0;
    cand_w   = '0;
    cand     = '0;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      if (mode_i == ARB_RR) begin
        cand_w = {1'b0, rr_ptr_i} + (IDX_W+1)'(i);
      end else begin
        cand_w = (IDX_W+1)'(i);
      end
      if (cand_w >= (IDX_W+1)'(NUM_REQ)) begin
        cand_w = cand_w - (IDX_W+1)'(NUM_REQ);
      end
      cand = cand_w[IDX_W-1:0];
      if (!valid_o && req_i[cand]) begin
        valid_o  = 1'b1;
        winner_o = cand;
      end
    end
  end

endmodule

// File: rtl/slink_tx_rr_router.sv
// rtl/slink_tx_rr_router.sv - S-Link TX application router, packet-locked arbitration (stats: SLINK_TX_RR_ROUTER_STATS_EN)
module slink_tx_rr_router
  import slink_tx_router_pkg::*;
#(
  parameter  int unsigned NUM_CHANNELS      = 8,
  parameter  int unsigned TX_APP_DATA_WIDTH = 64,
  parameter  logic [7:0]  SHORT_PKT_MAX_ID  = 8'h2F,
  localparam int unsigned CH_W              = $clog2(NUM_CHANNELS)
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  enable,
  input  logic                                  arb_mode,
  input  logic [NUM_CHANNELS-1:0]               ch_enable_mask,
  input  logic [NUM_CHANNELS-1:0]               tx_sop_ch,
  input  logic [NUM_CHANNELS*8-1:0]             tx_data_id_ch,
  input  logic [NUM_CHANNELS*16-1:0]            tx_word_count_ch,
  input  logic [NUM_CHANNELS*TX_APP_DATA_WIDTH-1:0] tx_app_data_ch,
  output logic [NUM_CHANNELS-1:0]               tx_advance_ch,
  output logic                                  tx_sop,
  output logic [7:0]                            tx_data_id,
  output logic [15:0]                           tx_word_count,
  output logic [TX_APP_DATA_WIDTH-1:0]          tx_app_data,
  input  logic                                  tx_advance,
  output logic [CH_W-1:0]                       grant_ch,
  output logic                                  busy,
  output logic                                  err_abort,
  input  logic                                  err_clear
`ifdef SLINK_TX_RR_ROUTER_STATS_EN
  ,
  input  logic                                  stats_clear,
  output logic [NUM_CHANNELS*16-1:0]            pkt_count_ch
`endif
);

  localparam int unsigned BPB_LOG2 = $clog2(TX_APP_DATA_WIDTH / 8);

  logic [7:0]                   id_arr   [NUM_CHANNELS];
  logic [15:0]                  wc_arr   [NUM_CHANNELS];
  logic [TX_APP_DATA_WIDTH-1:0] data_arr [NUM_CHANNELS];

  for (genvar g = 0; g < NUM_CHANNELS; g++) begin : g_unpack
    assign id_arr[g]   = tx_data_id_ch[g*8 +: 8];
    assign wc_arr[g]   = tx_word_count_ch[g*16 +: 16];
    assign data_arr[g] = tx_app_data_ch[g*TX_APP_DATA_WIDTH +: TX_APP_DATA_WIDTH];
  end

  state_e                  state_q, state_d;
  logic [CH_W-1:0]         grant_q, grant_d;
  logic [CH_W-1:0]         rr_ptr_q, rr_ptr_d;
  logic [BEAT_CNT_W-1:0]   beats_q, beats_d;
  logic                    err_q, err_d;
  logic                    pkt_done;
  logic                    enable_ff2;
  logic [NUM_CHANNELS-1:0] req;
  logic [CH_W-1:0]         arb_winner;
  logic                    arb_valid;
  logic [CH_W-1:0]         rr_next;

  slink_demet_reset u_enable_sync (
    .clk   (clk),
    .reset (reset),
    .sig_i (enable),
    .sig_o (enable_ff2)
  );

  assign req = tx_sop_ch & ch_enable_mask & {NUM_CHANNELS{enable_ff2}};

  slink_rr_arbiter #(
    .NUM_REQ (NUM_CHANNELS)
  ) u_arbiter (
    .req_i    (req),
    .rr_ptr_i (rr_ptr_q),
    .mode_i   (arb_mode),
    .winner_o (arb_winner),
    .valid_o  (arb_valid)
  );

  assign rr_next = (grant_q == CH_W'(NUM_CHANNELS - 1)) ? '0 : grant_q + 1'b1;

  // Data path always shows the granted channel, even while idle.
  assign tx_data_id    = id_arr[grant_q];
  assign tx_word_count = wc_arr[grant_q];
  assign tx_app_data   = data_arr[grant_q];
  assign grant_ch      = grant_q;
  assign busy          = (state_q == GRANT);
  assign err_abort     = err_q;

  // Arbitrate in IDLE; in GRANT count beats down and detect dropped requests.
  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    rr_ptr_d      = rr_ptr_q;
    beats_d       = beats_q;
    err_d         = err_q;
    tx_sop        = 1'b0;
    tx_advance_ch = '0;
    pkt_done      = 1'b0;
    if (err_clear) begin
      err_d = 1'b0;
    end
    case (state_q)
      IDLE: begin
        if (arb_valid) begin
          grant_d = arb_winner;
          beats_d = pkt_beats(id_arr[arb_winner], wc_arr[arb_winner],
                              SHORT_PKT_MAX_ID, BPB_LOG2);
          state_d = GRANT;
        end
      end
      GRANT: begin
        tx_sop                 = tx_sop_ch[grant_q];
        tx_advance_ch[grant_q] = tx_advance;
        if (!tx_sop_ch[grant_q]) begin
          // Source gave up mid-packet: flag it and move on as if it had finished.
          err_d    = 1'b1;
          rr_ptr_d = rr_next;
          state_d  = IDLE;
        end else if (tx_advance) begin
          if (beats_q == 17'd1) begin
            pkt_done = 1'b1;
            rr_ptr_d = rr_next;
            state_d  = IDLE;
          end else begin
            beats_d = beats_q - 17'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and grant registers; reset drops any packet in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      rr_ptr_q <= '0;
      beats_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      rr_ptr_q <= rr_ptr_d;
      beats_q  <= beats_d;
      err_q    <= err_d;
    end
  end

`ifdef SLINK_TX_RR_ROUTER_STATS_EN
  logic [15:0] pkt_cnt_q [NUM_CHANNELS];

  // Per-channel completed-packet counters; clear beats increment.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(NUM_CHANNELS); i++) pkt_cnt_q[i] <= '0;
    end else if (stats_clear) begin
      for (int i = 0; i < int'(NUM_CHANNELS); i++) pkt_cnt_q[i] <= '0;
    end else if (pkt_done) begin
      pkt_cnt_q[grant_q] <= pkt_cnt_q[grant_q] + 16'd1;
    end
  end

  for (genvar g = 0; g < NUM_CHANNELS; g++) begin : g_stats
    assign pkt_count_ch[g*16 +: 16] = pkt_cnt_q[g];
  end
`endif

endmodule

// File: tb/tb_slink_tx_rr_router.sv
// tb/tb_slink_tx_rr_router.sv - directed table-driven bench for slink_tx_rr_router
module tb_slink_tx_rr_router;

  localparam int N = 8;
  localparam int W = 64;

  logic             clk = 1'b0;
  logic             reset;
  logic             enable;
  logic             arb_mode;
  logic [N-1:0]     ch_enable_mask;
  logic [N-1:0]     tx_sop_ch;
  logic [N*8-1:0]   tx_data_id_ch;
  logic [N*16-1:0]  tx_word_count_ch;
  logic [N*W-1:0]   tx_app_data_ch;
  logic [N-1:0]     tx_advance_ch;
  logic             tx_sop;
  logic [7:0]       tx_data_id;
  logic [15:0]      tx_word_count;
  logic [W-1:0]     tx_app_data;
  logic             tx_advance;
  logic [2:0]       grant_ch;
  logic             busy;
  logic             err_abort;
  logic             err_clear;
`ifdef SLINK_TX_RR_ROUTER_STATS_EN
  logic             stats_clear;
  logic [N*16-1:0]  pkt_count_ch;
`endif

  logic [7:0]  id_a  [N];
  logic [15:0] wc_a  [N];
  logic [W-1:0] dat_a [N];

  always_comb begin
    tx_data_id_ch    = '0;
    tx_word_count_ch = '0;
    tx_app_data_ch   = '0;
    for (int i = 0; i < N; i++) begin
      tx_data_id_ch[i*8 +: 8]    = id_a[i];
      tx_word_count_ch[i*16 +: 16] = wc_a[i];
      tx_app_data_ch[i*W +: W]   = dat_a[i];
    end
  end

  always #5 clk = ~clk;

  slink_tx_rr_router #(
    .NUM_CHANNELS      (N),
    .TX_APP_DATA_WIDTH (W),
    .SHORT_PKT_MAX_ID  (8'h2F)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .enable           (enable),
    .arb_mode         (arb_mode),
    .ch_enable_mask   (ch_enable_mask),
    .tx_sop_ch        (tx_sop_ch),
    .tx_data_id_ch    (tx_data_id_ch),
    .tx_word_count_ch (tx_word_count_ch),
    .tx_app_data_ch   (tx_app_data_ch),
    .tx_advance_ch    (tx_advance_ch),
    .tx_sop           (tx_sop),
    .tx_data_id       (tx_data_id),
    .tx_word_count    (tx_word_count),
    .tx_app_data      (tx_app_data),
    .tx_advance       (tx_advance),
    .grant_ch         (grant_ch),
    .busy             (busy),
    .err_abort        (err_abort),
    .err_clear        (err_clear)
`ifdef SLINK_TX_RR_ROUTER_STATS_EN
    ,
    .stats_clear      (stats_clear),
    .pkt_count_ch     (pkt_count_ch)
`endif
  );

  typedef struct {
    logic [7:0] sop;
    logic [7:0] mask;
    logic       mode;
    logic       adv;
    logic       exp_sop;
    logic [2:0] exp_grant;
    logic       exp_busy;
    logic [7:0] exp_adv_ch;
  } vec_t;

  vec_t vecs[$];
  int n_cmp  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input logic [7:0] sop, input logic [7:0] mask, input logic mode,
                     input logic adv, input logic e_sop, input logic [2:0] e_grant,
                     input logic e_busy, input logic [7:0] e_adv_ch);
    vec_t v;
    v.sop = sop; v.mask = mask; v.mode = mode; v.adv = adv;
    v.exp_sop = e_sop; v.exp_grant = e_grant; v.exp_busy = e_busy; v.exp_adv_ch = e_adv_ch;
    vecs.push_back(v);
  endtask

  // Requests one channel alone and counts forwarded advances until the grant releases.
  task automatic measure(input int ch, input logic [7:0] id, input logic [15:0] wc,
                         input bit toggle, input string name,
                         output int beats, output int cyc);
    bit route_ok;
    bit done;
    beats = 0; cyc = 0; route_ok = 1'b1; done = 1'b0;
    @(negedge clk);
    id_a[ch] = id; wc_a[ch] = wc;
    tx_sop_ch = 8'(1 << ch); tx_advance = 1'b0;
    for (int guard = 0; guard < 20000 && !done; guard++) begin
      @(negedge clk);
      if (busy) begin
        tx_advance = toggle ? cyc[0] : 1'b1;
        #1;
        if (tx_advance_ch !== (tx_advance ? 8'(1 << ch) : 8'h00)) route_ok = 1'b0;
        if (grant_ch !== 3'(ch) || tx_sop !== 1'b1) route_ok = 1'b0;
        if (tx_advance) beats++;
        cyc++;
      end else if (cyc != 0) begin
        done = 1'b1;
      end else begin
        tx_advance = 1'b0;
      end
    end
    tx_sop_ch = '0; tx_advance = 1'b0;
    id_a[ch] = 8'h10 + 8'(ch); wc_a[ch] = 16'(ch + 1);
    chk({name, "_completed"}, 64'(done), 64'd1);
    chk({name, "_route"}, 64'(route_ok), 64'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int beats, cyc, k;
    bit stayed_idle;

    for (int i = 0; i < N; i++) begin
      id_a[i]  = 8'h10 + 8'(i);
      wc_a[i]  = 16'(i + 1);
      dat_a[i] = 64'hA5A5_5A5A_0000_0000 | 64'(i);
    end
    reset = 1'b1; enable = 1'b1; arb_mode = 1'b0; ch_enable_mask = 8'hFF;
    tx_sop_ch = 8'hFF; tx_advance = 1'b1; err_clear = 1'b0;
`ifdef SLINK_TX_RR_ROUTER_STATS_EN
    stats_clear = 1'b0;
`endif

    // Reset state
    repeat (3) @(negedge clk);
    #1;
    chk("rst_tx_sop", 64'(tx_sop), 64'd0);
    chk("rst_adv_ch", 64'(tx_advance_ch), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_err", 64'(err_abort), 64'd0);
    chk("rst_grant", 64'(grant_ch), 64'd0);
    chk("rst_data_id", 64'(tx_data_id), 64'(id_a[0]));
    chk("rst_wc", 64'(tx_word_count), 64'(wc_a[0]));
    chk("rst_data", tx_app_data, dat_a[0]);

    @(negedge clk);
    reset = 1'b0; tx_sop_ch = '0;
    repeat (4) @(negedge clk);
    #1;
    chk("idle_adv_ignored", 64'(tx_advance_ch), 64'd0);

    // Round-robin, all channels requesting short packets
    for (k = 0; k <= 8; k++) begin
      add(8'hFF, 8'hFF, 1'b1, 1'b1, 1'b0, (k == 0) ? 3'd0 : 3'(k - 1), 1'b0, 8'h00);
      add(8'hFF, 8'hFF, 1'b1, 1'b1, 1'b1, 3'(k % 8), 1'b1, 8'(1 << (k % 8)));
    end
    // Fixed priority: channels 1, 3, 5
    add(8'h2A, 8'hFF, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 8'h00);
    add(8'h2A, 8'hFF, 1'b0, 1'b1, 1'b1, 3'd1, 1'b1, 8'h02);
    add(8'h28, 8'hFF, 1'b0, 1'b1, 1'b0, 3'd1, 1'b0, 8'h00);
    add(8'h28, 8'hFF, 1'b0, 1'b1, 1'b1, 3'd3, 1'b1, 8'h08);
    add(8'h20, 8'hFF, 1'b0, 1'b1, 1'b0, 3'd3, 1'b0, 8'h00);
    add(8'h20, 8'hFF, 1'b0, 1'b1, 1'b1, 3'd5, 1'b1, 8'h20);
    add(8'h00, 8'hFF, 1'b0, 1'b1, 1'b0, 3'd5, 1'b0, 8'h00);
    // Masked channel 0 never wins
    add(8'h01, 8'hFE, 1'b0, 1'b1, 1'b0, 3'd5, 1'b0, 8'h00);
    add(8'h01, 8'hFE, 1'b0, 1'b1, 1'b0, 3'd5, 1'b0, 8'h00);
    add(8'h01, 8'hFE, 1'b0, 1'b1, 1'b0, 3'd5, 1'b0, 8'h00);
    add(8'h03, 8'hFE, 1'b0, 1'b1, 1'b0, 3'd5, 1'b0, 8'h00);
    add(8'h03, 8'hFE, 1'b0, 1'b1, 1'b1, 3'd1, 1'b1, 8'h02);
    add(8'h01, 8'hFE, 1'b0, 1'b1, 1'b0, 3'd1, 1'b0, 8'h00);

    for (int v = 0; v < vecs.size(); v++) begin
      @(negedge clk);
      tx_sop_ch = vecs[v].sop; ch_enable_mask = vecs[v].mask;
      arb_mode = vecs[v].mode; tx_advance = vecs[v].adv;
      #1;
      chk($sformatf("vec%0d_tx_sop", v), 64'(tx_sop), 64'(vecs[v].exp_sop));
      chk($sformatf("vec%0d_grant", v), 64'(grant_ch), 64'(vecs[v].exp_grant));
      chk($sformatf("vec%0d_busy", v), 64'(busy), 64'(vecs[v].exp_busy));
      chk($sformatf("vec%0d_adv_ch", v), 64'(tx_advance_ch), 64'(vecs[v].exp_adv_ch));
    end
    @(negedge clk);
    tx_sop_ch = '0; ch_enable_mask = 8'hFF; arb_mode = 1'b0; tx_advance = 1'b0;
    @(negedge clk);

    // Beat counting
    measure(2, 8'h40, 16'd0, 1'b0, "wc0", beats, cyc);
    chk("wc0_beats", 64'(beats), 64'd1);
    measure(2, 8'h40, 16'd20, 1'b0, "wc20", beats, cyc);
    chk("wc20_beats", 64'(beats), 64'd3);
    measure(2, 8'h2F, 16'd100, 1'b0, "short_max", beats, cyc);
    chk("short_max_beats", 64'(beats), 64'd1);
    measure(2, 8'h30, 16'd9, 1'b0, "long_min", beats, cyc);
    chk("long_min_beats", 64'(beats), 64'd2);
    measure(3, 8'h40, 16'd32, 1'b1, "bp", beats, cyc);
    chk("bp_beats", 64'(beats), 64'd4);
    chk("bp_cycles", 64'(cyc), 64'd8);
    measure(5, 8'h40, 16'hFFFF, 1'b0, "wcmax", beats, cyc);
    chk("wcmax_beats", 64'(beats), 64'd8192);

    // Grant locked for a 3-beat packet while ch0 asks
    @(negedge clk);
    id_a[2] = 8'h40; wc_a[2] = 16'd20; tx_sop_ch = 8'h04; tx_advance = 1'b1;
    @(negedge clk);
    tx_sop_ch = 8'h05;
    #1;
    chk("lock_b1_grant", 64'(grant_ch), 64'd2);
    chk("lock_data_id", 64'(tx_data_id), 64'h40);
    chk("lock_wc", 64'(tx_word_count), 64'd20);
    chk("lock_data", tx_app_data, dat_a[2]);
    @(negedge clk); #1;
    chk("lock_b2_grant", 64'(grant_ch), 64'd2);
    @(negedge clk); #1;
    chk("lock_b3_adv_ch", 64'(tx_advance_ch), 64'h04);
    @(negedge clk);
    tx_sop_ch = 8'h01;
    #1;
    chk("lock_gap_busy", 64'(busy), 64'd0);
    @(negedge clk); #1;
    chk("lock_ch0_grant", 64'(grant_ch), 64'd0);
    chk("lock_ch0_busy", 64'(busy), 64'd1);
    @(negedge clk);
    tx_sop_ch = '0; tx_advance = 1'b0;
    id_a[2] = 8'h12; wc_a[2] = 16'd3;

    // Enable drop mid-packet
    @(negedge clk);
    id_a[1] = 8'h40; wc_a[1] = 16'd32; tx_sop_ch = 8'h02; tx_advance = 1'b1;
    @(negedge clk);
    enable = 1'b0;
    #1;
    chk("en_busy_start", 64'(busy), 64'd1);
    repeat (3) @(negedge clk);
    #1;
    chk("en_busy_last_beat", 64'(busy), 64'd1);
    stayed_idle = 1'b1;
    repeat (5) begin
      @(negedge clk); #1;
      if (busy !== 1'b0) stayed_idle = 1'b0;
    end
    chk("en_stays_idle", 64'(stayed_idle), 64'd1);
    enable = 1'b1; tx_sop_ch = '0; tx_advance = 1'b0;
    id_a[1] = 8'h11; wc_a[1] = 16'd2;
    repeat (3) @(negedge clk);

    // Abort and error clear
    id_a[4] = 8'h40; wc_a[4] = 16'd32; tx_sop_ch = 8'h10; tx_advance = 1'b0;
    @(negedge clk);
    tx_advance = 1'b1;
    #1;
    chk("ab_b1_adv_ch", 64'(tx_advance_ch), 64'h10);
    @(negedge clk);
    tx_sop_ch = '0;
    #1;
    chk("ab_adv_forwarded", 64'(tx_advance_ch), 64'h10);
    chk("ab_tx_sop_low", 64'(tx_sop), 64'd0);
    chk("ab_err_not_yet", 64'(err_abort), 64'd0);
    @(negedge clk);
    tx_advance = 1'b0;
    #1;
    chk("ab_err_set", 64'(err_abort), 64'd1);
    chk("ab_idle", 64'(busy), 64'd0);
    err_clear = 1'b1;
    @(negedge clk);
    err_clear = 1'b0;
    #1;
    chk("ab_err_cleared", 64'(err_abort), 64'd0);
    @(negedge clk);
    tx_sop_ch = 8'h10;
    @(negedge clk); #1;
    chk("ab2_busy", 64'(busy), 64'd1);
    @(negedge clk);
    tx_sop_ch = '0; err_clear = 1'b1;
    @(negedge clk);
    err_clear = 1'b0;
    #1;
    chk("ab_set_beats_clear", 64'(err_abort), 64'd1);
    err_clear = 1'b1;
    @(negedge clk);
    err_clear = 1'b0;
    id_a[4] = 8'h14; wc_a[4] = 16'd5;

    // Asynchronous reset in the middle of a packet
    @(negedge clk);
    id_a[3] = 8'h40; wc_a[3] = 16'd64; tx_sop_ch = 8'h08; tx_advance = 1'b1;
    @(negedge clk); #1;
    chk("ar_busy_before", 64'(busy), 64'd1);
    #2 reset = 1'b1;
    #1;
    chk("ar_busy", 64'(busy), 64'd0);
    chk("ar_tx_sop", 64'(tx_sop), 64'd0);
    chk("ar_adv_ch", 64'(tx_advance_ch), 64'd0);
    chk("ar_grant", 64'(grant_ch), 64'd0);
    @(negedge clk);
    reset = 1'b0; tx_sop_ch = '0; tx_advance = 1'b0;
    id_a[3] = 8'h13; wc_a[3] = 16'd4;
    repeat (4) @(negedge clk);

`ifdef SLINK_TX_RR_ROUTER_STATS_EN
    for (int p = 0; p < 5; p++) begin
      measure(6, 8'h16, 16'd7, 1'b0, "st_pkt", beats, cyc);
    end
    @(negedge clk);
    id_a[6] = 8'h40; wc_a[6] = 16'd32; tx_sop_ch = 8'h40; tx_advance = 1'b1;
    @(negedge clk);
    @(negedge clk);
    tx_sop_ch = '0;
    @(negedge clk);
    tx_advance = 1'b0; err_clear = 1'b1;
    #1;
    chk("st_count6", 64'(pkt_count_ch[6*16 +: 16]), 64'd5);
    chk("st_count0", 64'(pkt_count_ch[0 +: 16]), 64'd0);
    stats_clear = 1'b1;
    @(negedge clk);
    stats_clear = 1'b0; err_clear = 1'b0;
    #1;
    chk("st_cleared", 64'(pkt_count_ch[6*16 +: 16]), 64'd0);
    id_a[6] = 8'h16; wc_a[6] = 16'd7;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/slink_tx_rr_router.md
Name: slink_tx_rr_router

Overview:
- Next-generation S-Link TX application router: arbitrates NUM_CHANNELS packet sources onto one link-layer TX interface.
- Arbitration mode is selectable at runtime: fixed-priority or round-robin.
- Per-channel enable mask; the grant is locked for a whole packet by counting beats from word count and data ID.
- Sits between application channel sources and the slink link-layer TX.

Parameters:
- NUM_CHANNELS, 8, number of source channels (2..32).
- TX_APP_DATA_WIDTH, 64, app data bits per beat; must be 8 x power of 2.
- SHORT_PKT_MAX_ID, 8'h2F, data IDs <= this value are short packets (1 beat).

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- enable  in  1  router enable; async, synchronized internally with 2 flops.
- arb_mode  in  1  0 = fixed priority (lowest index wins); 1 = round-robin.
- ch_enable_mask  in  NUM_CHANNELS  1 = channel eligible for arbitration.
- tx_sop_ch  in  NUM_CHANNELS  per-channel request; held high through the packet until its last advance.
- tx_data_id_ch  in  NUM_CHANNELS*8  per-channel data ID.
- tx_word_count_ch  in  NUM_CHANNELS*16  per-channel word count (bytes).
- tx_app_data_ch  in  NUM_CHANNELS*TX_APP_DATA_WIDTH  per-channel payload.
- tx_advance_ch  out  NUM_CHANNELS  advance routed to the granted channel only.
- tx_sop  out  1  to link layer.
- tx_data_id  out  8  to link layer.
- tx_word_count  out  16  to link layer.
- tx_app_data  out  TX_APP_DATA_WIDTH  to link layer.
- tx_advance  in  1  link layer accepted the current beat.
- grant_ch  out  clog2(NUM_CHANNELS)  currently granted channel.
- busy  out  1  packet in flight.
- err_abort  out  1  sticky: a request dropped mid-packet.
- err_clear  in  1  synchronous clear for err_abort.

Behaviour:
- Reset values:
  - State IDLE; grant_ch = 0; rr pointer = 0; busy = 0; err_abort = 0.
  - tx_sop = 0; tx_advance_ch = 0.
  - tx_data_id, tx_word_count and tx_app_data follow the channel-0 mux.
- Eligible request: req[i] = tx_sop_ch[i] & ch_enable_mask[i] & enable_ff2.
- State IDLE:
  - Outputs mux channel grant_ch; tx_sop = 0.
  - If any req is set: select the winner.
    - arb_mode 0: lowest eligible index.
    - arb_mode 1: first eligible index at or after rr_ptr, wrapping at NUM_CHANNELS-1 -> 0.
  - Register grant_ch = winner and go to GRANT. Arbitration latency is 1 cycle (request to tx_sop high).
- State GRANT:
  - tx_sop = tx_sop_ch[grant_ch]; tx_advance_ch[grant_ch] = tx_advance.
  - On entry, beats_left loads from the granted channel:
    - short packet (data_id <= SHORT_PKT_MAX_ID): 1.
    - long packet: max(1, ceil(word_count / (TX_APP_DATA_WIDTH/8))), computed as (wc + BPB-1) >> log2(BPB) in 17-bit arithmetic (wc = 16'hFFFF does not overflow).
  - Each tx_advance decrements beats_left.
  - On the advance with beats_left == 1:
    - packet done; rr_ptr = (grant_ch+1) mod NUM_CHANNELS.
    - go to IDLE.
    - The next arbitration occurs in IDLE the following cycle: one idle cycle between packets.
- busy = (state == GRANT).
- Mask and arb_mode changes are sampled only in IDLE; a packet in flight is never preempted.
- enable deasserted during GRANT: the current packet completes, then the router stays IDLE.
- tx_sop_ch[grant_ch] falls in GRANT before the last advance:
  - set err_abort; go to IDLE; rr_ptr advances as if the packet completed.
  - tx_advance on that same cycle is still forwarded.
- err_clear and a new abort on the same cycle: set wins.
- tx_advance while IDLE: ignored; tx_advance_ch stays 0.
- Async reset mid-packet: immediately returns to the reset state; no partial-packet recovery.

Optional Feature:
- Macro: SLINK_TX_RR_ROUTER_STATS_EN.
- Defined:
  - Adds output pkt_count_ch [NUM_CHANNELS*16]: per-channel completed-packet counters.
  - Aborts are not counted; counters wrap 16'hFFFF -> 0; reset to 0.
  - Adds input stats_clear, which zeroes all counters synchronously and has priority over increment.
- Undefined: the ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Shared package slink_tx_router_pkg:
  - state encoding (IDLE = 1'b0, GRANT = 1'b1);
  - arb_mode encodings ARB_FIXED = 0, ARB_RR = 1;
  - short/long classification function;
  - beat-count function.
- Sub-module slink_rr_arbiter: combinational masked round-robin/fixed-priority pick.
  - Inputs: req, rr_ptr, mode.
  - Outputs: winner index and valid.
  - Reusable by an RX-side scheduler.
- Synchronizer: the existing slink_demet_reset.

Test Plan:
- Fixed priority: arb_mode=0, ch 1, 3, 5 request together with short IDs (8'h10), tx_advance always high -> grants 1, 3, 5 in that order; tx_sop high 1 cycle each, each followed by 1 idle cycle.
- Round-robin fairness: arb_mode=1, all 8 channels request continuously (short) -> grants 0,1,...,7,0; each channel gets exactly 1 of 8 packets per cycle.
- Long packet lock: TX_APP_DATA_WIDTH=64, ch2 ID 8'h40 with wc=20 -> 3 beats; ch0 requests mid-packet; ch0 is not granted until after the 3rd advance. Also check wc=0 -> 1 beat and wc=16'hFFFF -> 8192 beats.
- Backpressure and mask:
  - tx_advance toggles 1/0 -> beats_left decrements only on advance.
  - ch_enable_mask=8'hFE with ch0 requesting -> ch0 is never granted.
  - enable=0 mid-packet -> packet finishes, then busy stays 0.
- Abort: ch4 long packet drops tx_sop_ch after beat 1 of 4 -> err_abort=1, IDLE next cycle; err_clear clears it; simultaneous abort and clear leaves err_abort=1.
- Stats (macro defined): 5 completes on ch6 and 1 abort -> pkt_count_ch[6]=5; stats_clear -> 0; 65536 packets wraps to 0.
